// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM state encodings and grant owner codes.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_lat_cnt.sv
// Loadable down-counter timing the fixed memory latency; done flags the last wait cycle.
module arb_lat_cnt #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory port between I-cache fill and D-cache fill/writeback.
// Define ARB_ROUND_ROBIN_EN to replace fixed D-over-I priority with round-robin on conflicts.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MEM_LAT = 2,
    parameter int AW      = 16,
    parameter int DW      = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_wr,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_stall,
    input  logic          mem_err,
    output logic          owner,
    output logic          busy,
    output logic          err
);

    localparam int CW = $clog2(MEM_LAT + 1);

    arb_state_e    state_q;
    logic          owner_q;
    logic          wr_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;
    logic          err_q;
    logic          i_ack_q;
    logic          d_ack_q;
    logic          grant_d;
    logic          cnt_load;
    logic          cnt_done;

`ifdef ARB_ROUND_ROBIN_EN
    logic          last_owner_q;
`endif

    always_comb begin
        grant_d = d_req ? OWN_D : OWN_I;
`ifdef ARB_ROUND_ROBIN_EN
        // On a conflict the side that did not win last time gets the port.
        if (i_req && d_req) begin
            grant_d = ~last_owner_q;
        end
`endif
    end

    assign cnt_load = (state_q == ST_ISSUE) && !mem_stall;

    arb_lat_cnt #(
        .W(CW)
    ) u_lat_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (CW'(MEM_LAT)),
        .dec_i      (state_q == ST_WAIT),
        .done_o     (cnt_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_I;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            i_ack_q <= 1'b0;
            d_ack_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner_q <= OWN_I;
`endif
        end else begin
            i_ack_q <= 1'b0;
            d_ack_q <= 1'b0;
            if (((state_q == ST_ISSUE) || (state_q == ST_WAIT)) && mem_err) begin
                err_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (i_req || d_req) begin
                        owner_q <= grant_d;
`ifdef ARB_ROUND_ROBIN_EN
                        last_owner_q <= grant_d;
`endif
                        if (grant_d == OWN_D) begin
                            addr_q  <= d_addr;
                            wr_q    <= d_wr;
                            wdata_q <= d_wdata;
                        end else begin
                            addr_q  <= i_addr;
                            wr_q    <= 1'b0;
                        end
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!mem_stall) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_done) begin
                        if (!wr_q) begin
                            rdata_q <= mem_rdata;
                        end
                        i_ack_q <= (owner_q == OWN_I);
                        d_ack_q <= (owner_q == OWN_D);
                        state_q <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Strobes are gated by the live stall so a refused access is simply retried next cycle.
    assign mem_rd    = (state_q == ST_ISSUE) && !wr_q && !mem_stall;
    assign mem_wr    = (state_q == ST_ISSUE) &&  wr_q && !mem_stall;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign i_ack     = i_ack_q;
    assign d_ack     = d_ack_q;
    assign i_rdata   = rdata_q;
    assign d_rdata   = rdata_q;
    assign owner     = owner_q;
    assign busy      = (state_q != ST_IDLE);
    assign err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter with a fixed-latency memory model.
// Honours ARB_ROUND_ROBIN_EN when predicting the winner of a conflict.
module tb_mem_arbiter;

    localparam int LAT = 2;
    localparam int AW  = 16;
    localparam int DW  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_ack;
    logic [DW-1:0] i_rdata;
    logic          d_req;
    logic          d_wr;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          mem_rd;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_stall;
    logic          mem_err;
    logic          owner;
    logic          busy;
    logic          err;

    mem_arbiter #(.MEM_LAT(LAT), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ack     (i_ack),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_wr      (d_wr),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_stall (mem_stall),
        .mem_err   (mem_err),
        .owner     (owner),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: read data is valid only in the cycle exactly LAT after the strobe.
    logic [DW-1:0] mem [0:1023];
    logic [LAT-1:0] pv = '0;
    logic [DW-1:0]  pd [LAT];

    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr[9:0]] = mem_wdata;
        pv[0] <= mem_rd;
        pd[0] <= mem[mem_addr[9:0]];
        for (int k = 1; k < LAT; k++) begin
            pv[k] <= pv[k-1];
            pd[k] <= pd[k-1];
        end
    end

    assign mem_rdata = pv[LAT-1] ? pd[LAT-1] : 16'hDEAD;

    int            rd_cnt = 0;
    int            wr_cnt = 0;
    int            both_cnt = 0;
    int            ack_cnt = 0;
    int            strobe_cyc = -1;
    logic [AW-1:0] strobe_addr = '0;
    logic [DW-1:0] strobe_wdata = '0;

    always @(negedge clk) begin
        if (mem_rd || mem_wr) begin
            strobe_cyc   = cyc;
            strobe_addr  = mem_addr;
            strobe_wdata = mem_wdata;
        end
        if (mem_rd) rd_cnt++;
        if (mem_wr) wr_cnt++;
        if (mem_rd && mem_wr) both_cnt++;
        if (i_ack || d_ack) ack_cnt++;
    end

    typedef struct {
        logic          side;
        logic [DW-1:0] rdata;
        logic          wr;
        int            ack_cyc;
    } exp_t;

    exp_t sb[$];
    logic tb_last = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic side, input logic [DW-1:0] rdata, input logic wr, input int ack_cyc);
        exp_t e;
        e.side = side; e.rdata = rdata; e.wr = wr; e.ack_cyc = ack_cyc;
        sb.push_back(e);
    endtask

    task automatic wait_ack(input string tag);
        exp_t e;
        int n = 0;
        while (!(i_ack || d_ack) && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_ack_seen"}, 32'(i_ack | d_ack), 32'd1);
        chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_d_ack"}, 32'(d_ack), 32'(e.side));
            chk({tag, "_i_ack"}, 32'(i_ack), 32'(!e.side));
            chk({tag, "_ack_cyc"}, 32'(cyc), 32'(e.ack_cyc));
            if (!e.wr) chk({tag, "_rdata"}, 32'(e.side ? d_rdata : i_rdata), 32'(e.rdata));
            tb_last = e.side;
        end
        if (d_ack) d_req = 1'b0;
        if (i_ack) i_req = 1'b0;
        step();
        chk({tag, "_ack_pulse"}, 32'(i_ack | d_ack), 32'd0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_owner"}, 32'(owner), 32'd0);
        chk({tag, "_err"},   32'(err), 32'd0);
        chk({tag, "_acks"},  32'({i_ack, d_ack}), 32'd0);
        chk({tag, "_strb"},  32'({mem_rd, mem_wr}), 32'd0);
        chk({tag, "_rdata"}, 32'({i_rdata, d_rdata}), 32'd0);
        chk({tag, "_maddr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mwdat"}, 32'(mem_wdata), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int r0;
        int w0;
        int a0;
        logic first;

        for (int k = 0; k < 1024; k++) mem[k] = '0;
        mem[10'h040] = 16'h1234;
        mem[10'h044] = 16'h5678;
        mem[10'h200] = 16'hAAAA;
        rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_wr = 1'b0;
        d_addr = '0; d_wdata = '0; mem_stall = 1'b0; mem_err = 1'b0;
        step(); step();
        check_reset("reset");
        rst = 1'b0;
        step();

        // I read alone
        i_req = 1'b1; i_addr = 16'h0040; s = cyc; r0 = rd_cnt;
        push(1'b0, 16'h1234, 1'b0, s + 2 + LAT);
        step();
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_owner", 32'(owner), 32'd0);
        wait_ack("t1");
        chk("t1_rd_cnt", 32'(rd_cnt - r0), 32'd1);
        chk("t1_strobe_cyc", 32'(strobe_cyc), 32'(s + 1));
        chk("t1_strobe_addr", 32'(strobe_addr), 32'h0040);

        // D write
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0100; d_wdata = 16'hBEEF;
        s = cyc; r0 = rd_cnt; w0 = wr_cnt;
        push(1'b1, 16'h0000, 1'b1, s + 2 + LAT);
        wait_ack("t2");
        d_wr = 1'b0;
        chk("t2_wr_cnt", 32'(wr_cnt - w0), 32'd1);
        chk("t2_rd_cnt", 32'(rd_cnt - r0), 32'd0);
        chk("t2_strobe_cyc", 32'(strobe_cyc), 32'(s + 1));
        chk("t2_strobe_addr", 32'(strobe_addr), 32'h0100);
        chk("t2_strobe_wdata", 32'(strobe_wdata), 32'hBEEF);
        chk("t2_mem", 32'(mem[10'h100]), 32'hBEEF);

        // Conflict: both requests rise together
        i_req = 1'b1; i_addr = 16'h0200; d_req = 1'b1; d_addr = 16'h0100; s = cyc;
`ifdef ARB_ROUND_ROBIN_EN
        first = ~tb_last;
`else
        first = 1'b1;
`endif
        push(first, first ? 16'hBEEF : 16'hAAAA, 1'b0, s + 2 + LAT);
        push(!first, first ? 16'hAAAA : 16'hBEEF, 1'b0, s + 2 * (3 + LAT) - 1);
        wait_ack("t3a");
        wait_ack("t3b");

        // Stall for three cycles in ISSUE
        i_req = 1'b1; i_addr = 16'h0044; mem_stall = 1'b1; s = cyc; r0 = rd_cnt;
        push(1'b0, 16'h5678, 1'b0, s + 5 + LAT);
        step(); step(); step();
        chk("t4_no_strobe", 32'(rd_cnt - r0), 32'd0);
        step();
        mem_stall = 1'b0;
        wait_ack("t4");
        chk("t4_rd_cnt", 32'(rd_cnt - r0), 32'd1);
        chk("t4_strobe_cyc", 32'(strobe_cyc), 32'(s + 4));

        // Reset during WAIT
        d_req = 1'b1; d_addr = 16'h0100; s = cyc; r0 = rd_cnt; a0 = ack_cnt;
        step(); step();
        chk("t5_wait_busy", 32'(busy), 32'd1);
        rst = 1'b1; d_req = 1'b0;
        step();
        rst = 1'b0; tb_last = 1'b0;
        chk("t5_busy_after_rst", 32'(busy), 32'd0);
        chk("t5_strobe_after_rst", 32'({mem_rd, mem_wr}), 32'd0);
        for (int k = 0; k < 6; k++) step();
        chk("t5_no_ack", 32'(ack_cnt - a0), 32'd0);
        chk("t5_rd_cnt", 32'(rd_cnt - r0), 32'd1);
        i_req = 1'b1; i_addr = 16'h0040; s = cyc;
        push(1'b0, 16'h1234, 1'b0, s + 2 + LAT);
        wait_ack("t5_new");

        // Error pulse during WAIT is sticky until reset
        d_req = 1'b1; d_addr = 16'h0200; s = cyc;
        push(1'b1, 16'hAAAA, 1'b0, s + 2 + LAT);
        step();
        chk("t6_err_before", 32'(err), 32'd0);
        step();
        mem_err = 1'b1;
        step();
        mem_err = 1'b0;
        wait_ack("t6");
        chk("t6_err_set", 32'(err), 32'd1);
        i_req = 1'b1; i_addr = 16'h0040; s = cyc;
        push(1'b0, 16'h1234, 1'b0, s + 2 + LAT);
        wait_ack("t6_next");
        chk("t6_err_sticky", 32'(err), 32'd1);
        rst = 1'b1;
        step(); step();
        check_reset("final_reset");
        rst = 1'b0;

        chk("one_strobe", 32'(both_cnt), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
